piece_sequencer: RTL and testbench

- Generates the Tetris piece stream using a 7-bag randomiser.
- Drives `next_block` into the colour generator's preview field.
- Hands the current piece to the game FSM through a req/valid handshake.
- Holds a free-running 16-bit LFSR and a 7-bit bag mask, and sequences one bounded-latency draw per piece.

---
 rtl/piece_sequencer_if.sv | 21 ++
 rtl/piece_sequencer.sv | 124 ++++++++++++
 tb/tb_piece_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piece_sequencer_if.sv
// Piece hand-off bundle between the piece sequencer and the game FSM.
// master: game FSM side (drives restart/piece_req, observes the piece stream).
// slave : sequencer side (drives ready/piece_valid/cur_block/next_block).
interface piece_sequencer_if;
  logic       restart;
  logic       piece_req;
  logic       ready;
  logic       piece_valid;
  logic [2:0] cur_block;
  logic [2:0] next_block;

  modport master (
    output restart, piece_req,
    input  ready, piece_valid, cur_block, next_block
  );

  modport slave (
    input  restart, piece_req,
    output ready, piece_valid, cur_block, next_block
  );
endinterface

// File: rtl/piece_sequencer.sv
// Tetris piece stream generator: 7-bag randomiser driven by a free-running
// Galois LFSR, one bounded (1..8 cycle) draw per piece.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-low
//   bus  - slave side of piece_sequencer_if:
//          restart/piece_req in; ready, piece_valid, cur_block, next_block out
module piece_sequencer #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  piece_sequencer_if.slave bus
);
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned SLOTS  = 7;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [SLOTS-1:0]  BAG_FULL  = 7'h7F;

  typedef enum logic [1:0] {ST_INIT, ST_READY, ST_DRAW} state_t;

  state_t              state, state_nxt;
  logic [LFSR_W-1:0]   lfsr;
  logic [SLOTS-1:0]    bag, bag_nxt, bag_clr;
  logic [2:0]          tries, tries_nxt;
  logic [CODE_W-1:0]   cur_q, cur_nxt, next_q, next_nxt;
  logic                valid_q, valid_nxt, ready_q;
  logic [SLOTS:0]      bag_ext;
  logic [2:0]          cand, low_slot, pick;
  logic                cand_hit, accept;

  // Slot 6 (Z) maps to code 111; code 110 is unused.
  function automatic logic [CODE_W-1:0] slot_code(input logic [2:0] s);
    return (s == 3'd6) ? 3'd7 : s;
  endfunction

  // Free-running LFSR, never stalls and is not reseeded by restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= SEED;
    else      lfsr <= {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  // Draw datapath: candidate hit test plus lowest-free-slot fallback.
  always_comb begin
    cand     = lfsr[2:0];
    bag_ext  = {1'b0, bag};          // bit 7 is zero, so candidate 7 never hits
    cand_hit = bag_ext[cand];
    low_slot = 3'd0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (bag[i]) low_slot = 3'(i);
    end
    pick     = cand_hit ? cand : low_slot;
    accept   = cand_hit || (tries == 3'd7);
    bag_clr  = bag & ~(SLOTS'(1) << pick);
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt = state;
    bag_nxt   = bag;
    tries_nxt = tries;
    cur_nxt   = cur_q;
    next_nxt  = next_q;
    valid_nxt = 1'b0;

    case (state)
      ST_INIT, ST_DRAW: begin
        if (accept) begin
          next_nxt  = slot_code(pick);
          bag_nxt   = (bag_clr == '0) ? BAG_FULL : bag_clr;
          tries_nxt = 3'd0;
          state_nxt = ST_READY;
        end else begin
          tries_nxt = tries + 3'd1;
        end
      end
      ST_READY: begin
        if (bus.piece_req) begin
          cur_nxt   = next_q;
          valid_nxt = 1'b1;
          state_nxt = ST_DRAW;
        end
      end
      default: state_nxt = ST_INIT;
    endcase

    // New game overrides any same-cycle accept or request.
    if (bus.restart) begin
      state_nxt = ST_INIT;
      bag_nxt   = BAG_FULL;
      tries_nxt = 3'd0;
      cur_nxt   = cur_q;
      next_nxt  = next_q;
      valid_nxt = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_INIT;
      bag     <= BAG_FULL;
      tries   <= 3'd0;
      cur_q   <= '0;
      next_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      bag     <= bag_nxt;
      tries   <= tries_nxt;
      cur_q   <= cur_nxt;
      next_q  <= next_nxt;
      valid_q <= valid_nxt;
      ready_q <= (state_nxt == ST_READY);
    end
  end

  assign bus.ready       = ready_q;
  assign bus.piece_valid = valid_q;
  assign bus.cur_block   = cur_q;
  assign bus.next_block  = next_q;
endmodule

// File: tb/tb_piece_sequencer.sv
// Directed self-checking bench for piece_sequencer: reset values, first
// draws for two seeds, 70-piece bag permutation run, held request, restart
// priority, forced 8-attempt fallback and async reset mid-draw.
module tb_piece_sequencer;
  localparam logic [15:0] SEED_A = 16'hACE1;
  localparam logic [15:0] SEED_B = 16'h0007;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  piece_sequencer_if bus_a();
  piece_sequencer_if bus_b();

  piece_sequencer #(.SEED(SEED_A)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  piece_sequencer #(.SEED(SEED_B)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [15:0] m_lfsr;
  logic [6:0]  m_bag  = 7'h7F;
  logic [2:0]  m_next = 3'd0;
  logic [2:0]  m_cur  = 3'd0;
  int          m_reqs = 0;

  logic [2:0]  cur_log [70];
  int          n_log  = 0;
  bit          log_en = 1'b0;

  int   pulses = 0, b2b = 0, bad_acc = 0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [2:0] slot_code(input logic [2:0] s);
    return (s == 3'd6) ? 3'd7 : s;
  endfunction

  // Walk up to 8 attempts from the LFSR value seen by the first attempt.
  function automatic void model_draw(input logic [15:0] l0, input logic [6:0] b,
                                     output logic [2:0] slot, output int k);
    logic [15:0] l;
    logic [7:0]  b8;
    l = l0;
    b8 = {1'b0, b};
    slot = 3'd0;
    k = 8;
    for (int t = 0; t < 8; t++) begin
      if (b8[l[2:0]]) begin
        slot = l[2:0];
        k = t + 1;
        return;
      end
      l = lfsr_step(l);
    end
    for (int i = 6; i >= 0; i--) if (b[i]) slot = 3'(i);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED_A;
    else      m_lfsr <= lfsr_step(m_lfsr);
  end

  // Pulse monitor on DUT A.
  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (bus_a.piece_valid === 1'b1) begin
        pulses++;
        if (prev_valid === 1'b1) b2b++;
        if (prev_ready !== 1'b1) bad_acc++;
      end
      prev_valid = bus_a.piece_valid;
      prev_ready = bus_a.ready;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge right after entering INIT/DRAW; follows the draw to READY.
  task automatic finish_draw(output int lat);
    logic [2:0] slot;
    logic [2:0] old;
    int k, bad;
    model_draw(m_lfsr, m_bag, slot, k);
    old = m_next;
    lat = 0;
    bad = 0;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus_a.piece_valid !== 1'b0) bad++;
      if (bus_a.ready === 1'b1) lat = i;
      else if (bus_a.next_block !== old) bad++;
    end
    check_eq("draw_lat", lat, k);
    check_eq("draw_next", bus_a.next_block, slot_code(slot));
    check_eq("draw_hold", bad, 0);
    m_next = slot_code(slot);
    m_bag  = m_bag & ~(7'(1) << slot);
    if (m_bag == 7'h00) m_bag = 7'h7F;
  endtask

  task automatic do_request(input bit hold_req, input int gap, output int lat);
    repeat (gap) begin @(posedge clk); @(negedge clk); end
    check_eq("req_ready", bus_a.ready, 1);
    bus_a.piece_req = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!hold_req) bus_a.piece_req = 1'b0;
    check_eq("req_valid", bus_a.piece_valid, 1);
    check_eq("req_cur", bus_a.cur_block, m_next);
    check_eq("req_ready_lo", bus_a.ready, 0);
    m_cur = m_next;
    m_reqs++;
    if (log_en && n_log < 70) begin
      cur_log[n_log] = m_cur;
      n_log++;
    end
    finish_draw(lat);
  endtask

  // Wait in READY until a request/restart at the next edge sees n candidates all in ok.
  task automatic wait_window(input logic [7:0] ok, input int n, output bit found);
    logic [15:0] l;
    bit good;
    found = 1'b0;
    for (int w = 0; w < 3000 && !found; w++) begin
      l = lfsr_step(m_lfsr);
      good = 1'b1;
      for (int a = 0; a < n; a++) begin
        if (!ok[l[2:0]]) good = 1'b0;
        l = lfsr_step(l);
      end
      if (good) found = 1'b1;
      else begin @(posedge clk); @(negedge clk); end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0;
    bit found;
    logic [7:0] mask;

    bus_a.restart = 1'b0; bus_a.piece_req = 1'b0;
    bus_b.restart = 1'b0; bus_b.piece_req = 1'b0;

    // Reset values while rst is held low across an edge.
    @(negedge clk); @(negedge clk);
    check_eq("rst_ready", bus_a.ready, 0);
    check_eq("rst_valid", bus_a.piece_valid, 0);
    check_eq("rst_cur", bus_a.cur_block, 0);
    check_eq("rst_next", bus_a.next_block, 0);
    check_eq("rst_bag", u_dut_a.bag, 7'h7F);
    check_eq("rst_lfsr", u_dut_a.lfsr, SEED_A);
    rst = 1'b1;

    // First draw: ACE1 -> T on attempt 1; 0007 -> reject, then L on attempt 2.
    finish_draw(lat);
    check_eq("a_first_lat", lat, 1);
    check_eq("a_first_next", bus_a.next_block, 3'b001);
    check_eq("b_edge1_ready", bus_b.ready, 0);
    check_eq("b_edge1_next", bus_b.next_block, 0);
    @(posedge clk); @(negedge clk);
    check_eq("b_edge2_ready", bus_b.ready, 1);
    check_eq("b_edge2_next", bus_b.next_block, 3'b011);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check_eq("a_idle_cur", bus_a.cur_block, 0);
    check_eq("a_idle_valid", bus_a.piece_valid, 0);
    check_eq("a_idle_ready", bus_a.ready, 1);

    // 70 requests with small random idle gaps.
    p0 = pulses;
    log_en = 1'b1;
    for (int r = 0; r < 70; r++) do_request(1'b0, int'($urandom_range(0, 2)), lat);
    log_en = 1'b0;
    check_eq("pulses_70", pulses - p0, 70);
    for (int b = 0; b < 10; b++) begin
      mask = 8'h00;
      for (int j = 0; j < 7; j++) mask[cur_log[7*b + j]] = 1'b1;
      check_eq($sformatf("perm_blk%0d", b), mask, 8'hBF);
    end

    // Request held high: only accepted while ready, never queued.
    for (int r = 0; r < 10; r++) do_request(1'b1, 0, lat);
    bus_a.piece_req = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check_eq("no_queue_valid", bus_a.piece_valid, 0);
      check_eq("no_queue_ready", bus_a.ready, 1);
    end

    // Restart during DRAW beats the pending accept.
    bus_a.piece_req = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_a.piece_req = 1'b0;
    check_eq("rsd_req_valid", bus_a.piece_valid, 1);
    m_cur = m_next;
    m_reqs++;
    bus_a.restart = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_a.restart = 1'b0;
    check_eq("rsd_valid", bus_a.piece_valid, 0);
    check_eq("rsd_ready", bus_a.ready, 0);
    check_eq("rsd_next_hold", bus_a.next_block, m_next);
    check_eq("rsd_bag", u_dut_a.bag, 7'h7F);
    m_bag = 7'h7F;
    finish_draw(lat);
    check_eq("rsd_lat_le8", (lat >= 1 && lat <= 8), 1);

    // Restart together with a request in READY: request dropped.
    bus_a.piece_req = 1'b1;
    bus_a.restart = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_a.piece_req = 1'b0;
    bus_a.restart = 1'b0;
    check_eq("rsr_valid", bus_a.piece_valid, 0);
    check_eq("rsr_cur_hold", bus_a.cur_block, m_cur);
    check_eq("rsr_ready", bus_a.ready, 0);
    check_eq("rsr_bag", u_dut_a.bag, 7'h7F);
    m_bag = 7'h7F;
    finish_draw(lat);
    check_eq("rsr_lat_le8", (lat >= 1 && lat <= 8), 1);

    // Steer five draws onto slots 0,1,3,4,6 leaving bag = 7'b0100100.
    wait_window(8'h5B, 1, found);
    check_eq("steer_rs_found", found, 1);
    bus_a.restart = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_a.restart = 1'b0;
    m_bag = 7'h7F;
    finish_draw(lat);
    for (int s = 0; s < 4; s++) begin
      wait_window(8'h5B & {1'b0, m_bag}, 1, found);
      check_eq("steer_found", found, 1);
      do_request(1'b0, 0, lat);
    end
    check_eq("fb_bag_pre", u_dut_a.bag, 7'b0100100);
    // Eight rejects in a row force the lowest free slot (2 -> O).
    wait_window(8'hDB, 8, found);
    check_eq("fb_found", found, 1);
    do_request(1'b0, 0, lat);
    check_eq("fb_lat", lat, 8);
    check_eq("fb_next", bus_a.next_block, 3'b010);

    // Async reset in the middle of a draw.
    bus_a.piece_req = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_a.piece_req = 1'b0;
    check_eq("ar_req_valid", bus_a.piece_valid, 1);
    m_reqs++;
    #2 rst = 1'b0;
    #1;
    check_eq("ar_ready", bus_a.ready, 0);
    check_eq("ar_valid", bus_a.piece_valid, 0);
    check_eq("ar_cur", bus_a.cur_block, 0);
    check_eq("ar_next", bus_a.next_block, 0);
    check_eq("ar_bag", u_dut_a.bag, 7'h7F);
    m_bag = 7'h7F;
    m_next = 3'd0;
    m_cur = 3'd0;
    @(negedge clk);
    rst = 1'b1;
    finish_draw(lat);
    check_eq("ar_redraw_next", bus_a.next_block, 3'b001);

    repeat (2) begin @(posedge clk); @(negedge clk); end
    check_eq("pulse_total", pulses, m_reqs);
    check_eq("pulse_b2b", b2b, 0);
    check_eq("accept_not_ready", bad_acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
